// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction-fetch stage: PC register, SRAM request, instruction buffer, AdEL detect
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_allowin_in,
    input  logic [31:0] id_nextPC_in,
    input  logic        wb_ClrStpJmp_in,
    output logic        if_valid_out,
    output logic        inst_sram_en,
    output logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_rdata,
    output logic [31:0] if_PC_out,
    output logic [31:0] if_NPC_out,
    output logic [31:0] if_NNPC_out,
    output logic [31:0] if_NPC_fast_wire,
    output logic [31:0] if_Instruct_out,
    output logic        if_exception_out,
    output logic [4:0]  if_ExcCode_out,
    output logic [31:0] if_error_VAddr_out
);

    localparam logic [31:0] PC_INIT   = RESET_PC - 32'd4;
    localparam logic [4:0]  EXC_ADEL  = 5'h04;

    logic [31:0] pc_q;
    logic        valid_q;
    logic [31:0] inst_buf_q;
    logic        buf_valid_q;
    logic        fetch_pending_q;

    logic        allowin;
    logic        advance;
    logic        exc;

    // Flush overrides a decode stall; an empty stage always accepts.
    always_comb begin
        allowin = !valid_q || id_allowin_in;
        advance = allowin || wb_ClrStpJmp_in;
        exc     = valid_q && (pc_q[1:0] != 2'b00);
    end

    // SRAM request: misaligned targets are never presented to memory.
    always_comb begin
        inst_sram_addr = id_nextPC_in;
        inst_sram_en   = advance && rst_n && (id_nextPC_in[1:0] == 2'b00);
    end

    // PC/valid advance together with decode; returned data is parked while stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q            <= PC_INIT;
            valid_q         <= 1'b0;
            inst_buf_q      <= 32'd0;
            buf_valid_q     <= 1'b0;
            fetch_pending_q <= 1'b0;
        end else if (advance) begin
            pc_q            <= id_nextPC_in;
            valid_q         <= 1'b1;
            buf_valid_q     <= 1'b0;
            fetch_pending_q <= inst_sram_en;
        end else begin
            fetch_pending_q <= 1'b0;
            if (fetch_pending_q) begin
                inst_buf_q  <= inst_sram_rdata;
                buf_valid_q <= 1'b1;
            end
        end
    end

    // Decode-facing outputs; an excepting fetch is delivered as a nop.
    always_comb begin
        if_valid_out       = valid_q;
        if_PC_out          = pc_q;
        if_NPC_out         = pc_q + 32'd4;
        if_NNPC_out        = pc_q + 32'd8;
        if_NPC_fast_wire   = pc_q + 32'd4;
        if_exception_out   = exc;
        if_ExcCode_out     = exc ? EXC_ADEL : 5'd0;
        if_error_VAddr_out = exc ? pc_q : 32'd0;
        if (!valid_q || exc) begin
            if_Instruct_out = 32'd0;
        end else if (buf_valid_q) begin
            if_Instruct_out = inst_buf_q;
        end else begin
            if_Instruct_out = inst_sram_rdata;
        end
    end

endmodule
